// File: rtl/video_timing_ctrl.sv
// rtl/video_timing_ctrl.sv - raster timing generator with frame-buffer read requests and underflow tracking
module video_timing_ctrl #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic        video_clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        fifo_empty,
  input  logic        clr_underflow,
  output logic        video_hs,
  output logic        video_vs,
  output logic        video_de,
  output logic        rd_req,
  output logic        frame_start,
  output logic        line_start,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  output logic        busy,
  output logic        underflow,
  output logic [15:0] underflow_cnt
);

  localparam int H_TOTAL  = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL  = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int H_DE_BEG = H_SYNC + H_BP;
  localparam int H_DE_END = H_DE_BEG + H_ACTIVE;
  localparam int V_DE_BEG = V_SYNC + V_BP;
  localparam int V_DE_END = V_DE_BEG + V_ACTIVE;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t      state_q;
  logic [11:0] h_cnt_q, v_cnt_q;
  logic [11:0] h_cnt_d, v_cnt_d;
  logic        hs_q, vs_q, de_q, fs_q, ls_q, busy_q, uf_q;
  logic [11:0] pix_x_q, pix_y_q;
  logic [15:0] uf_cnt_q;

  logic        running, line_end, frame_end, h_in, v_in;
  logic        hs_d, vs_d, de_d, fs_d, ls_d, uf_d;
  logic [11:0] pix_x_d, pix_y_d;
  logic [15:0] uf_cnt_d;
  logic [12:0] h_ext, v_ext;

  assign h_ext = {1'b0, h_cnt_q};
  assign v_ext = {1'b0, v_cnt_q};

  // Decode of the current counters; everything here is registered one cycle later.
  always_comb begin
    running   = (state_q != IDLE);
    line_end  = (h_cnt_q == 12'(H_TOTAL - 1));
    frame_end = line_end && (v_cnt_q == 12'(V_TOTAL - 1));
    h_in      = (h_ext >= 13'(H_DE_BEG)) && (h_ext < 13'(H_DE_END));
    v_in      = (v_ext >= 13'(V_DE_BEG)) && (v_ext < 13'(V_DE_END));
    de_d      = running && h_in && v_in;
    hs_d      = (running && (h_ext < 13'(H_SYNC))) ? HS_POL : ~HS_POL;
    vs_d      = (running && (v_ext < 13'(V_SYNC))) ? VS_POL : ~VS_POL;
    fs_d      = running && (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
    ls_d      = running && (h_cnt_q == 12'd0);
    pix_x_d   = de_d ? (h_cnt_q - 12'(H_DE_BEG)) : 12'd0;
    pix_y_d   = de_d ? (v_cnt_q - 12'(V_DE_BEG)) : 12'd0;

    h_cnt_d = h_cnt_q + 12'd1;
    v_cnt_d = v_cnt_q;
    if (line_end) begin
      h_cnt_d = 12'd0;
      v_cnt_d = (v_cnt_q == 12'(V_TOTAL - 1)) ? 12'd0 : v_cnt_q + 12'd1;
    end

    // A fresh event beats a simultaneous clear so it is never lost.
    uf_d     = uf_q;
    uf_cnt_d = uf_cnt_q;
    if (rd_req && fifo_empty) begin
      uf_d     = 1'b1;
      uf_cnt_d = clr_underflow ? 16'd1 : ((uf_cnt_q == 16'hFFFF) ? 16'hFFFF : uf_cnt_q + 16'd1);
    end else if (clr_underflow) begin
      uf_d     = 1'b0;
      uf_cnt_d = 16'd0;
    end
  end

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      h_cnt_q  <= 12'd0;
      v_cnt_q  <= 12'd0;
      hs_q     <= ~HS_POL;
      vs_q     <= ~VS_POL;
      de_q     <= 1'b0;
      fs_q     <= 1'b0;
      ls_q     <= 1'b0;
      busy_q   <= 1'b0;
      uf_q     <= 1'b0;
      pix_x_q  <= 12'd0;
      pix_y_q  <= 12'd0;
      uf_cnt_q <= 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          h_cnt_q <= 12'd0;
          v_cnt_q <= 12'd0;
          if (enable) state_q <= RUN;
        end
        RUN, DRAIN: begin
          h_cnt_q <= h_cnt_d;
          v_cnt_q <= v_cnt_d;
          if (enable)         state_q <= RUN;
          else if (frame_end) state_q <= IDLE;
          else                state_q <= DRAIN;
        end
        default: state_q <= IDLE;
      endcase
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      de_q     <= de_d;
      fs_q     <= fs_d;
      ls_q     <= ls_d;
      busy_q   <= running;
      uf_q     <= uf_d;
      pix_x_q  <= pix_x_d;
      pix_y_q  <= pix_y_d;
      uf_cnt_q <= uf_cnt_d;
    end
  end

  assign video_hs      = hs_q;
  assign video_vs      = vs_q;
  assign video_de      = de_q;
  assign rd_req        = de_q;
  assign frame_start   = fs_q;
  assign line_start    = ls_q;
  assign pix_x         = pix_x_q;
  assign pix_y         = pix_y_q;
  assign busy          = busy_q;
  assign underflow     = uf_q;
  assign underflow_cnt = uf_cnt_q;

endmodule

// File: tb/tb_video_timing_ctrl.sv
// tb/tb_video_timing_ctrl.sv - scoreboard bench for video_timing_ctrl
module tb_video_timing_ctrl;

  localparam int HT = 15;
  localparam int VT = 7;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0, enable = 1'b0, fifo_empty = 1'b0, clr_underflow = 1'b0;
  logic video_hs, video_vs, video_de, rd_req, frame_start, line_start, busy, underflow;
  logic [11:0] pix_x, pix_y;
  logic [15:0] underflow_cnt;

  logic hs_n, vs_n, de_n, rd_n, fs_n, ls_n, busy_n, uf_n;
  logic [11:0] px_n, py_n;
  logic [15:0] cnt_n;

  logic rst_s_n = 1'b0;
  logic hs_s, vs_s, de_s, rd_s, fs_s, ls_s, busy_s, uf_s;
  logic [11:0] px_s, py_s;
  logic [15:0] cnt_s;

  video_timing_ctrl #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(3), .V_ACTIVE(4), .V_FP(1),
    .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1)) dut (
    .video_clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty),
    .clr_underflow(clr_underflow), .video_hs(video_hs), .video_vs(video_vs), .video_de(video_de),
    .rd_req(rd_req), .frame_start(frame_start), .line_start(line_start), .pix_x(pix_x),
    .pix_y(pix_y), .busy(busy), .underflow(underflow), .underflow_cnt(underflow_cnt));

  video_timing_ctrl #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(3), .V_ACTIVE(4), .V_FP(1),
    .V_SYNC(1), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0)) dut_n (
    .video_clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty),
    .clr_underflow(clr_underflow), .video_hs(hs_n), .video_vs(vs_n), .video_de(de_n),
    .rd_req(rd_n), .frame_start(fs_n), .line_start(ls_n), .pix_x(px_n),
    .pix_y(py_n), .busy(busy_n), .underflow(uf_n), .underflow_cnt(cnt_n));

  video_timing_ctrl #(.H_ACTIVE(4093), .H_FP(1), .H_SYNC(1), .H_BP(1), .V_ACTIVE(17), .V_FP(1),
    .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1)) dut_s (
    .video_clk(clk), .rst_n(rst_s_n), .enable(1'b1), .fifo_empty(1'b1),
    .clr_underflow(1'b0), .video_hs(hs_s), .video_vs(vs_s), .video_de(de_s),
    .rd_req(rd_s), .frame_start(fs_s), .line_start(ls_s), .pix_x(px_s),
    .pix_y(py_s), .busy(busy_s), .underflow(uf_s), .underflow_cnt(cnt_s));

  typedef struct packed {
    logic hs, vs, de, rd, fs, ls, bsy, uf;
    logic [11:0] px, py;
    logic [15:0] cnt;
  } out_t;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  out_t sb_q[$];
  out_t m_out = '0;
  int   m_st = 0;
  int   m_p = 0;

  task automatic model_step();
    out_t n;
    int   h, v;
    n = '0;
    if (!rst_n) begin
      m_st = 0; m_p = 0; m_out = '0;
      sb_q.push_back(n);
      return;
    end
    n.bsy = (m_st != 0);
    if (m_st != 0) begin
      h = m_p % HT;
      v = m_p / HT;
      n.hs = (h < 2);
      n.vs = (v < 1);
      n.de = (h >= 5) && (h < 13) && (v >= 2) && (v < 6);
      n.rd = n.de;
      n.fs = (m_p == 0);
      n.ls = (h == 0);
      if (n.de) begin
        n.px = 12'(h - 5);
        n.py = 12'(v - 2);
      end
    end
    n.uf  = m_out.uf;
    n.cnt = m_out.cnt;
    if (m_out.rd && fifo_empty) begin
      n.uf  = 1'b1;
      n.cnt = clr_underflow ? 16'd1 : ((m_out.cnt == 16'hFFFF) ? 16'hFFFF : m_out.cnt + 16'd1);
    end else if (clr_underflow) begin
      n.uf  = 1'b0;
      n.cnt = 16'd0;
    end
    if (m_st == 0) begin
      if (enable) m_st = 1;
    end else begin
      if (enable)                m_st = 1;
      else if (m_p == FRAME - 1) m_st = 0;
      else                       m_st = 2;
      m_p = (m_p + 1) % FRAME;
    end
    m_out = n;
    sb_q.push_back(n);
  endtask

  int cyc = 0, fs_last = -1, de_acc = 0, hs_acc = 0, vs_acc = 0;

  task automatic cycle();
    out_t exp, obs;
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    exp = sb_q.pop_front();
    obs = {video_hs, video_vs, video_de, rd_req, frame_start, line_start, busy, underflow,
           pix_x, pix_y, underflow_cnt};
    chk("raster", obs, exp);
    chk("raster_pol0", {hs_n, vs_n, de_n, fs_n}, {~exp.hs, ~exp.vs, exp.de, exp.fs});
    if (frame_start) begin
      if (fs_last >= 0) begin
        chk("fs_period", cyc - fs_last, FRAME);
        chk("de_per_frame", de_acc, 32);
        chk("hs_per_frame", hs_acc, 14);
        chk("vs_per_frame", vs_acc, 15);
      end
      fs_last = cyc;
      de_acc = 0; hs_acc = 0; vs_acc = 0;
    end
    de_acc += int'(video_de);
    hs_acc += int'(video_hs);
    vs_acc += int'(video_vs);
    if (!busy) fs_last = -1;
    @(negedge clk);
  endtask

  task automatic run_to(input int st, input int p);
    int i;
    for (i = 0; i < 400; i++) begin
      if (m_st == st && m_p == p) break;
      cycle();
    end
    if (i == 400) chk("run_to_timeout", 0, 1);
  endtask

  task automatic run_to_run_start();
    int i;
    for (i = 0; i < 400; i++) begin
      if (m_out.de && m_out.px == 12'd0) break;
      cycle();
    end
    if (i == 400) chk("de_wait_timeout", 0, 1);
  endtask

  bit s_done = 1'b0;

  initial begin
    bit  s_rd, s_rd_n, ev, s_run;
    int  s_p, s_ev, h, v, i;
    logic [15:0] s_exp;
    s_rd = 0; s_run = 0; s_p = 0; s_ev = 0;
    repeat (3) @(negedge clk);
    rst_s_n = 1'b1;
    for (i = 0; i < 80000; i++) begin
      ev = s_rd;
      if (ev) s_ev++;
      h = s_p % 4096;
      v = s_p / 4096;
      s_rd_n = s_run && (h >= 2) && (h < 4095) && (v >= 2) && (v < 19);
      if (s_run) s_p++; else s_run = 1;
      s_rd = s_rd_n;
      @(posedge clk);
      #1;
      if (ev && (s_ev == 65534 || s_ev == 65535 || s_ev == 65536 || s_ev == 65540)) begin
        s_exp = (s_ev >= 65535) ? 16'hFFFF : 16'(s_ev);
        chk("uf_sat_cnt", cnt_s, s_exp);
        chk("uf_sat_flag", uf_s, 1'b1);
      end
      @(negedge clk);
      if (s_ev >= 65540) break;
    end
    if (s_ev < 65540) chk("sat_bound", s_ev, 65540);
    s_done = 1'b1;
  end

  initial begin
    int nb, fsc;
    @(negedge clk);
    chk("reset_state", {video_hs, video_vs, video_de, rd_req, frame_start, line_start, busy,
        underflow, pix_x, pix_y, underflow_cnt}, 64'd0);
    chk("reset_pol0", {hs_n, vs_n}, 2'b11);
    repeat (3) cycle();
    rst_n = 1'b1;
    repeat (3) cycle();

    enable = 1'b1;
    cycle();
    chk("fs_lat_1", frame_start, 1'b0);
    cycle();
    chk("fs_lat_2", frame_start, 1'b1);
    repeat (3 * FRAME) cycle();

    run_to_run_start();
    fifo_empty = 1'b1;
    repeat (3) cycle();
    fifo_empty = 1'b0;
    cycle();
    chk("uf_flag", underflow, 1'b1);
    chk("uf_cnt3", underflow_cnt, 16'd3);
    clr_underflow = 1'b1;
    cycle();
    clr_underflow = 1'b0;
    chk("uf_clr_flag", underflow, 1'b0);
    chk("uf_clr_cnt", underflow_cnt, 16'd0);
    run_to_run_start();
    fifo_empty = 1'b1;
    repeat (2) cycle();
    clr_underflow = 1'b1;
    cycle();
    fifo_empty = 1'b0;
    clr_underflow = 1'b0;
    chk("uf_set_wins_flag", underflow, 1'b1);
    chk("uf_set_wins_cnt", underflow_cnt, 16'd1);

    run_to(1, 40);
    enable = 1'b0;
    nb = 0;
    for (int k = 0; k < 200; k++) begin
      cycle();
      if (busy) nb++; else break;
    end
    chk("drain_len", nb, 65);
    fsc = 0;
    for (int k = 0; k < 150; k++) begin
      cycle();
      fsc += int'(frame_start);
    end
    chk("idle_no_fs", fsc, 0);
    chk("idle_busy", busy, 1'b0);

    enable = 1'b1;
    repeat (2) cycle();
    run_to(1, 40);
    enable = 1'b0;
    repeat (10) cycle();
    enable = 1'b1;
    repeat (2 * FRAME) cycle();
    chk("redrain_busy", busy, 1'b1);

    run_to(1, 50);
    rst_n = 1'b0;
    #1;
    chk("async_rst", {video_hs, video_vs, video_de, rd_req, frame_start, line_start, busy,
        underflow, pix_x, pix_y, underflow_cnt}, 64'd0);
    chk("async_rst_pol0", {hs_n, vs_n, busy_n}, 3'b110);
    m_st = 0; m_p = 0; m_out = '0; fs_last = -1;
    enable = 1'b0;
    @(negedge clk);
    repeat (2) cycle();
    rst_n = 1'b1;
    enable = 1'b1;
    repeat (FRAME + 20) cycle();

    for (int k = 0; k < 90000 && !s_done; k++) @(posedge clk);
    if (!s_done) chk("sat_timeout", 0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
